seq_step_counter: RTL
=====================

Name: seq_step_counter

Overview:
- Parametrised step sequencer for the sequential multiplier datapath; generalises the fixed 2-bit partial-product step counter.
- Supplies the step index (count_out) that selects operand slices and shift amounts.
- Adds start/done handshake, enable-gated stepping, synchronous clear, configurable terminal count and one-shot/free-run mode.
- Sits between the multiplier control FSM and the partial-product mux/accumulator.

Parameters:
- WIDTH, 2, bit width of count_out; legal range 1..8.
- MAX_COUNT, 3, terminal step index; legal range 1..2^WIDTH-1. Elaboration error if out of range.
- MODE, 0, 0 = one-shot (run MAX_COUNT+1 steps, then done); 1 = free-run (wrap until sclr).

Ports:
- clk  input  1  rising-edge clock.
- aclr_n  input  1  asynchronous active-low reset; asserts immediately, deasserts synchronously to clk externally.
- start  input  1  request a new sequence; sampled only in IDLE or DONE.
- en  input  1  step enable; count advances only when en=1 in RUN.
- sclr  input  1  synchronous clear; highest synchronous priority.
- count_out  output  WIDTH  current step index.
- busy  output  1  high in RUN.
- last  output  1  high when busy=1 and count_out==MAX_COUNT.
- done  output  1  one-cycle pulse, see below.

Behaviour:
- Reset (aclr_n=0, asynchronous): state=IDLE, count_out=0, busy=0, last=0, done=0. Reset mid-sequence aborts with no done pulse.
- States: IDLE, RUN, DONE. All outputs are registered or decoded from registered state only; no input-to-output combinational path.
- Synchronous priority: sclr > start > en.
- sclr=1 in any state: next state IDLE, count_out=0, done=0.
- IDLE: start=1 -> RUN with count_out=0. Otherwise stay in IDLE.
- RUN, en=0: hold count_out and state (stall).
- RUN, en=1, count_out<MAX_COUNT: count_out+1.
- RUN, en=1, count_out==MAX_COUNT, MODE=0: -> DONE, count_out=0.
- RUN, en=1, count_out==MAX_COUNT, MODE=1: count_out=0, stay RUN, done=1 for that one cycle (wrap pulse).
- DONE: lasts exactly one cycle with done=1, busy=0. start=1 in DONE -> RUN (back-to-back sequence, no idle bubble); otherwise -> IDLE.
- start while in RUN: ignored.
- Latency, MODE=0, en held high: start sampled at edge e0 -> busy=1, count_out=0. Counts 1, 2, ... after e1, e2, ... Terminal count MAX_COUNT after edge e(MAX_COUNT). DONE after e(MAX_COUNT+1). IDLE after e(MAX_COUNT+2).
- Wrap arithmetic: count_out never exceeds MAX_COUNT. When MAX_COUNT=2^WIDTH-1, wrap occurs by natural overflow with identical behaviour.

Optional Feature:
- Macro: SEQ_STEP_CNT_ERR_EN.
- Defined: adds output err (1 bit), sticky. Set on the cycle after start=1 is sampled while in RUN. Cleared by sclr or aclr_n. err reset value 0. err does not alter the sequence.
- Undefined: no err port; start in RUN is silently ignored.

Decomposition:
- Package seq_mult_pkg holds:
  - the state typedef (IDLE, RUN, DONE, 2-bit encoding);
  - MODE constants MODE_ONESHOT=0 and MODE_FREERUN=1;
  - default WIDTH/MAX_COUNT for the 8x8 multiplier (2, 3).
- No sub-module: a single module is natural; the terminal-count compare is inline.

Test Plan:
- Reset: aclr_n=0 mid-RUN at count_out=2 -> all outputs 0 immediately; after release with start=0, state stays IDLE.
- One-shot, WIDTH=2, MAX_COUNT=3, en=1, start pulse -> count_out 0,1,2,3 with busy=1; last=1 only at 3; then done=1 for exactly 1 cycle with count_out=0; then IDLE.
- Stall: same setup, en=0 for 2 cycles at count_out=1 -> count_out holds 1, busy stays 1; total sequence stretches by 2 cycles; done still a single pulse.
- Back-to-back: start=1 during the DONE cycle -> next cycle busy=1, count_out=0, with no IDLE cycle in between.
- Free-run, MODE=1, WIDTH=3, MAX_COUNT=5, en=1 -> count_out 0..5,0..5; done pulses on each 5->0 wrap; sclr=1 at count_out=3 -> next cycle count_out=0, busy=0, done=0.
- With SEQ_STEP_CNT_ERR_EN defined: start=1 at count_out=1 -> err=1 next cycle and stays 1, sequence unaffected; sclr=1 -> err=0.

Source files
------------

// File: rtl/seq_mult_pkg.sv
// Shared types and constants for the sequential multiplier control path.
// Used by seq_step_counter for its state encoding and mode selection.
package seq_mult_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } step_state_t;

   localparam int MODE_ONESHOT = 0;
   localparam int MODE_FREERUN = 1;

   // Defaults match the 8x8 multiplier: four 2-bit partial-product steps.
   localparam int DEF_WIDTH     = 2;
   localparam int DEF_MAX_COUNT = 3;

endpackage

// File: rtl/seq_step_counter.sv
// Step sequencer producing the partial-product step index with start/done handshake.
// Optional macro SEQ_STEP_CNT_ERR_EN adds a sticky err output for start-while-busy.
module seq_step_counter
   import seq_mult_pkg::*;
#(
   parameter int WIDTH     = DEF_WIDTH,
   parameter int MAX_COUNT = DEF_MAX_COUNT,
   parameter int MODE      = MODE_ONESHOT
) (
   input  logic             clk,
   input  logic             aclr_n,
   input  logic             start,
   input  logic             en,
   input  logic             sclr,
   output logic [WIDTH-1:0] count_out,
   output logic             busy,
   output logic             last,
`ifdef SEQ_STEP_CNT_ERR_EN
   output logic             err,
`endif
   output logic             done
);

   if (WIDTH < 1 || WIDTH > 8) begin : g_bad_width
      $error("seq_step_counter: WIDTH must be in 1..8");
   end
   if (MAX_COUNT < 1 || MAX_COUNT > (1 << WIDTH) - 1) begin : g_bad_max
      $error("seq_step_counter: MAX_COUNT must be in 1..2^WIDTH-1");
   end
   if (MODE != MODE_ONESHOT && MODE != MODE_FREERUN) begin : g_bad_mode
      $error("seq_step_counter: MODE must be 0 or 1");
   end

   localparam logic [WIDTH-1:0] MAX_VAL = MAX_COUNT[WIDTH-1:0];

   step_state_t      state_q, state_n;
   logic [WIDTH-1:0] count_q, count_n;
   logic             done_q, done_n;

   always_ff @(posedge clk or negedge aclr_n) begin
      if (!aclr_n) begin
         state_q <= IDLE;
         count_q <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_n;
         count_q <= count_n;
         done_q  <= done_n;
      end
   end

   // done is registered so both the DONE cycle and a free-run wrap give a clean one-cycle pulse.
   always_comb begin
      state_n = state_q;
      count_n = count_q;
      done_n  = 1'b0;
      if (sclr) begin
         state_n = IDLE;
         count_n = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  state_n = RUN;
                  count_n = '0;
               end
            end
            RUN: begin
               if (en) begin
                  if (count_q == MAX_VAL) begin
                     count_n = '0;
                     done_n  = 1'b1;
                     if (MODE == MODE_ONESHOT) begin
                        state_n = DONE;
                     end
                  end else begin
                     count_n = count_q + 1'b1;
                  end
               end
            end
            DONE: begin
               count_n = '0;
               state_n = start ? RUN : IDLE;
            end
            default: begin
               state_n = IDLE;
               count_n = '0;
            end
         endcase
      end
   end

   assign count_out = count_q;
   assign busy      = (state_q == RUN);
   assign last      = busy && (count_q == MAX_VAL);
   assign done      = done_q;

`ifdef SEQ_STEP_CNT_ERR_EN
   logic err_q;

   always_ff @(posedge clk or negedge aclr_n) begin
      if (!aclr_n) begin
         err_q <= 1'b0;
      end else if (sclr) begin
         err_q <= 1'b0;
      end else if (state_q == RUN && start) begin
         err_q <= 1'b1;
      end
   end

   assign err = err_q;
`endif

endmodule
